ifetch_ir: RTL and testbench

- Fetch stage and instruction register of the multicycle MIPS core.
- Owns the PC, issues word reads to instruction memory over a req/ack handshake, and latches the returned word into the IR.
- Decodes the IR into fixed fields. imm_16 feeds the sign-extension stage directly downstream; opcode/funct feed the control FSM.

---
 rtl/mips_defs.sv | 36 +++
 rtl/ir_decode.sv | 26 ++
 rtl/ifetch_ir.sv | 133 +++++++++++++
 tb/tb_ifetch_ir.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the multicycle MIPS core: IR field positions,
// opcode constants and the fetch-stage state encoding.
package mips_defs;

   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 26;
   localparam int RS_HI     = 25;
   localparam int RS_LO     = 21;
   localparam int RT_HI     = 20;
   localparam int RT_LO     = 16;
   localparam int RD_HI     = 15;
   localparam int RD_LO     = 11;
   localparam int SHAMT_HI  = 10;
   localparam int SHAMT_LO  = 6;
   localparam int FUNCT_HI  = 5;
   localparam int FUNCT_LO  = 0;
   localparam int IMM_HI    = 15;
   localparam int IMM_LO    = 0;
   localparam int JADDR_HI  = 25;
   localparam int JADDR_LO  = 0;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ERR  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/ir_decode.sv
// Combinational field splitter for a MIPS instruction word; shared by the
// fetch stage and the trace/debug unit.
module ir_decode
   import mips_defs::*;
(
   input  logic [31:0] ir,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm_16,
   output logic [25:0] jaddr
);

   assign opcode = ir[OPCODE_HI:OPCODE_LO];
   assign rs     = ir[RS_HI:RS_LO];
   assign rt     = ir[RT_HI:RT_LO];
   assign rd     = ir[RD_HI:RD_LO];
   assign shamt  = ir[SHAMT_HI:SHAMT_LO];
   assign funct  = ir[FUNCT_HI:FUNCT_LO];
   assign imm_16 = ir[IMM_HI:IMM_LO];
   assign jaddr  = ir[JADDR_HI:JADDR_LO];

endmodule

// File: rtl/ifetch_ir.sv
// Fetch stage and instruction register: owns the PC, runs the req/ack read
// to instruction memory, latches the returned word and decodes it.
//
// state | meaning
// IDLE  | waiting for fetch_en; pc_we redirects the PC here
// REQ   | read outstanding, mem_req/mem_addr held until ack or timeout
// ERR   | ack timed out; terminal until rst
module ifetch_ir
   import mips_defs::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [7:0]  MAX_WAIT = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   input  logic        pc_we,
   input  logic [31:0] pc_next,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ir,
   output logic        ir_valid,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm_16,
   output logic [25:0] jaddr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        busy,
   output logic        fetch_err
);

   fetch_state_t state, state_nxt;
   logic [7:0]   wait_cnt;
   logic         redir_pend;
   logic         do_fetch, do_accept, do_discard, do_redir, do_timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      do_fetch   = 1'b0;
      do_accept  = 1'b0;
      do_discard = 1'b0;
      do_redir   = 1'b0;
      do_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (pc_we) begin
               do_redir = 1'b1;
            end else if (fetch_en) begin
               do_fetch  = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            do_redir = pc_we;
            if (mem_ack) begin
               state_nxt = IDLE;
               // a redirect seen at any point during the read makes the word stale
               if (redir_pend || pc_we) do_discard = 1'b1;
               else                     do_accept  = 1'b1;
            end else if (wait_cnt == MAX_WAIT - 8'd1) begin
               do_timeout = 1'b1;
               state_nxt  = ERR;
            end
         end
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc         <= RESET_PC;
         ir         <= 32'h0;
         ir_valid   <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= 32'h0;
         fetch_err  <= 1'b0;
         wait_cnt   <= 8'h0;
         redir_pend <= 1'b0;
      end else begin
         if (do_redir)       pc <= pc_next & ~32'd3;
         else if (do_accept) pc <= mem_addr + 32'd4;

         if (do_accept) ir <= mem_rdata;

         if (do_accept)                ir_valid <= 1'b1;
         else if (do_fetch || do_redir) ir_valid <= 1'b0;

         if (do_fetch) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
         end else if (do_accept || do_discard || do_timeout) begin
            mem_req  <= 1'b0;
         end

         if (do_timeout) fetch_err <= 1'b1;

         if (do_fetch)                      wait_cnt <= 8'h0;
         else if (state == REQ && !mem_ack) wait_cnt <= wait_cnt + 8'd1;

         if (do_fetch || do_accept || do_discard) redir_pend <= 1'b0;
         else if (do_redir && state == REQ)       redir_pend <= 1'b1;
      end
   end

   assign pc_plus4 = pc + 32'd4;
   assign busy     = (state == REQ);

   ir_decode u_ir_decode (
      .ir     (ir),
      .opcode (opcode),
      .rs     (rs),
      .rt     (rt),
      .rd     (rd),
      .shamt  (shamt),
      .funct  (funct),
      .imm_16 (imm_16),
      .jaddr  (jaddr)
   );

endmodule

// File: tb/tb_ifetch_ir.sv
// Directed bench for ifetch_ir: the bench plays instruction memory and the
// control FSM, driving on falling edges and checking on falling edges.
module tb_ifetch_ir;
   import mips_defs::*;

   localparam int MAXW = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic        pc_we;
   logic [31:0] pc_next;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] ir;
   logic        ir_valid;
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  funct;
   logic [15:0] imm_16;
   logic [25:0] jaddr;
   logic [31:0] pc, pc_plus4;
   logic        busy;
   logic        fetch_err;

   int n_cmp = 0;
   int n_bad = 0;

   ifetch_ir #(.RESET_PC(32'h0000_0000), .MAX_WAIT(8'd255)) dut (
      .clk       (clk),
      .rst       (rst),
      .fetch_en  (fetch_en),
      .pc_we     (pc_we),
      .pc_next   (pc_next),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .ir        (ir),
      .ir_valid  (ir_valid),
      .opcode    (opcode),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .shamt     (shamt),
      .funct     (funct),
      .imm_16    (imm_16),
      .jaddr     (jaddr),
      .pc        (pc),
      .pc_plus4  (pc_plus4),
      .busy      (busy),
      .fetch_err (fetch_err)
   );

   always #5 clk = ~clk;

   // stimulus helpers only; all comparisons live in the test tasks
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; fetch_en = 1'b0; pc_we = 1'b0; pc_next = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // pulses fetch_en; returns on the falling edge where mem_req has risen
   task automatic start_fetch();
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
   endtask

   // one-cycle ack; returns on the falling edge after the accepting edge
   task automatic give_ack(input logic [31:0] data);
      mem_ack = 1'b1; mem_rdata = data;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = '0;
   endtask

   task automatic redirect(input logic [31:0] tgt);
      pc_we = 1'b1; pc_next = tgt;
      @(negedge clk);
      pc_we = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if ({pc, ir, ir_valid, mem_req, mem_addr, fetch_err, busy} !== {32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL reset_state: pc=%h ir=%h v=%b req=%b addr=%h err=%b busy=%b, expected all zero", pc, ir, ir_valid, mem_req, mem_addr, fetch_err, busy);
      end
      n_cmp++; if (pc_plus4 !== 32'h4) begin
         n_bad++; $display("FAIL reset_pc_plus4: got %h expected 00000004", pc_plus4);
      end
   endtask

   task automatic test_single_fetch();
      apply_reset();
      start_fetch();
      n_cmp++; if ({mem_req, busy, mem_addr} !== {1'b1, 1'b1, 32'h0}) begin
         n_bad++; $display("FAIL single_req: req=%b busy=%b addr=%h expected 1 1 00000000", mem_req, busy, mem_addr);
      end
      give_ack(32'h2008_0005);
      n_cmp++; if ({ir, ir_valid, pc, mem_req, busy} !== {32'h2008_0005, 1'b1, 32'h4, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL single_ir: ir=%h v=%b pc=%h req=%b busy=%b expected 20080005 1 00000004 0 0", ir, ir_valid, pc, mem_req, busy);
      end
      n_cmp++; if ({opcode, rs, rt, imm_16, rd, shamt, funct, jaddr} !== {6'h08, 5'd0, 5'd8, 16'h0005, 5'd0, 5'd0, 6'h05, 26'h008_0005}) begin
         n_bad++; $display("FAIL single_decode: op=%h rs=%0d rt=%0d imm=%h rd=%0d sh=%0d fn=%h j=%h expected 08 0 8 0005 0 0 05 0080005", opcode, rs, rt, imm_16, rd, shamt, funct, jaddr);
      end
      n_cmp++; if (pc_plus4 !== 32'h8) begin
         n_bad++; $display("FAIL single_pc_plus4: got %h expected 00000008", pc_plus4);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [3];
      logic [31:0] exp_ir;
      words[0] = 32'h0000_0820;
      words[1] = 32'h8C22_0010;
      words[2] = 32'hAC43_FFFC;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         start_fetch();
         for (int w = 0; w < 3; w++) begin
            n_cmp++; if ({mem_req, busy, mem_addr} !== {1'b1, 1'b1, 32'(4 * i)}) begin
               n_bad++; $display("FAIL b2b_req_hold[%0d.%0d]: req=%b busy=%b addr=%h expected 1 1 %h", i, w, mem_req, busy, mem_addr, 32'(4 * i));
            end
            if (w < 2) @(negedge clk);
         end
         give_ack(words[i]);
         exp_ir = words[i];
         n_cmp++; if ({ir, ir_valid, busy, mem_req} !== {exp_ir, 1'b1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL b2b_ir[%0d]: ir=%h v=%b busy=%b req=%b expected %h 1 0 0", i, ir, ir_valid, busy, mem_req, exp_ir);
         end
      end
      n_cmp++; if (pc !== 32'd12) begin
         n_bad++; $display("FAIL b2b_pc: got %h expected 0000000c", pc);
      end
   endtask

   task automatic test_redirect_idle();
      apply_reset();
      start_fetch();
      give_ack(32'h0000_0001);
      redirect(32'h0000_0103);
      n_cmp++; if ({pc, ir_valid, mem_req} !== {32'h0000_0100, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL idle_redirect: pc=%h v=%b req=%b expected 00000100 0 0", pc, ir_valid, mem_req);
      end
      start_fetch();
      n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin
         n_bad++; $display("FAIL idle_redirect_fetch: req=%b addr=%h expected 1 00000100", mem_req, mem_addr);
      end
      give_ack(32'h1234_0000);
      fetch_en = 1'b1;
      redirect(32'h0000_0202);
      fetch_en = 1'b0;
      n_cmp++; if ({pc, mem_req, busy, ir_valid} !== {32'h0000_0200, 1'b0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL redirect_beats_fetch: pc=%h req=%b busy=%b v=%b expected 00000200 0 0 0", pc, mem_req, busy, ir_valid);
      end
   endtask

   task automatic test_redirect_req();
      apply_reset();
      start_fetch();
      give_ack(32'h1234_5678);
      start_fetch();
      redirect(32'h0000_0040);
      n_cmp++; if ({pc, mem_req, mem_addr} !== {32'h40, 1'b1, 32'h4}) begin
         n_bad++; $display("FAIL req_redirect_hold: pc=%h req=%b addr=%h expected 00000040 1 00000004", pc, mem_req, mem_addr);
      end
      give_ack(32'hDEAD_BEEF);
      n_cmp++; if ({ir, ir_valid, pc, mem_req} !== {32'h1234_5678, 1'b0, 32'h40, 1'b0}) begin
         n_bad++; $display("FAIL req_redirect_discard: ir=%h v=%b pc=%h req=%b expected 12345678 0 00000040 0", ir, ir_valid, pc, mem_req);
      end
      start_fetch();
      n_cmp++; if (mem_addr !== 32'h40) begin
         n_bad++; $display("FAIL req_redirect_next: addr=%h expected 00000040", mem_addr);
      end
      // redirect coincident with the ack also discards the word
      pc_we = 1'b1; pc_next = 32'h0000_0087;
      give_ack(32'hCAFE_F00D);
      pc_we = 1'b0;
      n_cmp++; if ({ir, ir_valid, pc} !== {32'h1234_5678, 1'b0, 32'h84}) begin
         n_bad++; $display("FAIL ack_cycle_redirect: ir=%h v=%b pc=%h expected 12345678 0 00000084", ir, ir_valid, pc);
      end
   endtask

   task automatic test_wrap_timeout();
      apply_reset();
      redirect(32'hFFFF_FFFF);
      start_fetch();
      n_cmp++; if (mem_addr !== 32'hFFFF_FFFC) begin
         n_bad++; $display("FAIL wrap_addr: got %h expected fffffffc", mem_addr);
      end
      give_ack(32'h0800_0000);
      n_cmp++; if ({pc, pc_plus4, fetch_err} !== {32'h0, 32'h4, 1'b0}) begin
         n_bad++; $display("FAIL wrap_pc: pc=%h p4=%h err=%b expected 00000000 00000004 0", pc, pc_plus4, fetch_err);
      end
      start_fetch();
      repeat (MAXW - 1) @(negedge clk);
      n_cmp++; if ({fetch_err, mem_req, busy} !== {1'b0, 1'b1, 1'b1}) begin
         n_bad++; $display("FAIL timeout_early: err=%b req=%b busy=%b expected 0 1 1", fetch_err, mem_req, busy);
      end
      repeat (2) @(negedge clk);
      n_cmp++; if ({fetch_err, mem_req, busy} !== {1'b1, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL timeout_err: err=%b req=%b busy=%b expected 1 0 0", fetch_err, mem_req, busy);
      end
      fetch_en = 1'b1;
      redirect(32'h0000_0500);
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      @(negedge clk);
      n_cmp++; if ({fetch_err, mem_req, pc} !== {1'b1, 1'b0, 32'h0}) begin
         n_bad++; $display("FAIL err_sticky: err=%b req=%b pc=%h expected 1 0 00000000", fetch_err, mem_req, pc);
      end
      apply_reset();
      n_cmp++; if ({fetch_err, busy} !== {1'b0, 1'b0}) begin
         n_bad++; $display("FAIL err_reset: err=%b busy=%b expected 0 0", fetch_err, busy);
      end
   endtask

   task automatic test_reset_mid_req();
      apply_reset();
      start_fetch();
      give_ack(32'h1111_2222);
      start_fetch();
      #2 rst = 1'b1;
      #1;
      n_cmp++; if ({pc, ir, ir_valid, mem_req, mem_addr} !== {32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
         n_bad++; $display("FAIL async_reset: pc=%h ir=%h v=%b req=%b addr=%h expected all zero", pc, ir, ir_valid, mem_req, mem_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      give_ack(32'h3333_4444);
      @(negedge clk);
      n_cmp++; if ({pc, ir, ir_valid, mem_req, busy} !== {32'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL late_ack_ignored: pc=%h ir=%h v=%b req=%b busy=%b expected 0 0 0 0 0", pc, ir, ir_valid, mem_req, busy);
      end
   endtask

   initial begin
      rst = 1'b1; fetch_en = 1'b0; pc_we = 1'b0; pc_next = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_redirect_idle();
      test_redirect_req();
      test_wrap_timeout();
      test_reset_mid_req();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
